// File: rtl/load_align_unit.sv
// Sequential load unit: issues one or two aligned bus reads, merges the beats,
// and returns the addressed byte/half/word/dword sign- or zero-extended.
module load_align_unit #(
    parameter int DW              = 32,
    parameter int AW              = 32,
    parameter int ALLOW_UNALIGNED = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_op,
    output logic          bus_req_valid,
    input  logic          bus_req_ready,
    output logic [AW-1:0] bus_addr,
    input  logic          bus_rsp_valid,
    input  logic [DW-1:0] bus_rsp_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam logic [DW-1:0] ERR_DATA = {NB{8'hdd}};

    typedef enum logic [2:0] {IDLE, BUS0, WAIT0, BUS1, WAIT1, RESP} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   addr_q;
    logic [2:0]      op_q;
    logic [DW-1:0]   beat0_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic [AW-1:0]   base;
    logic [2*DW-1:0] merged;
    logic [DW-1:0]   result;

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'b011, 3'b100: op_size = 2;
            3'b101, 3'b111: op_size = 4;
            3'b110:         op_size = 8;
            default:        op_size = 1;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        op_legal = (op != 3'b000) && !(DW == 32 && (op == 3'b101 || op == 3'b110));
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [LB-1:0] off);
        misaligned = (int'(off) % op_size(op)) != 0;
    endfunction

    function automatic logic crosses(input logic [2:0] op, input logic [LB-1:0] off);
        crosses = (int'(off) + op_size(op)) > NB;
    endfunction

    // Shift the two-beat window down to the addressed byte, then mask and extend.
    function automatic logic [DW-1:0] extract(input logic [2*DW-1:0] m,
                                              input logic [LB-1:0]   off,
                                              input logic [2:0]      op);
        logic [2*DW-1:0] sh;
        logic [DW-1:0]   f;
        logic [DW-1:0]   ones;
        logic [DW-1:0]   mask;
        logic            sb;
        sh   = m >> (int'(off) * 8);
        f    = sh[DW-1:0];
        ones = '1;
        mask = ~(ones << (op_size(op) * 8));
        case (op)
            3'b010:  sb = f[7];
            3'b100:  sb = f[15];
            3'b111:  sb = f[31];
            default: sb = 1'b0;
        endcase
        extract = (f & mask) | (sb ? ~mask : '0);
    endfunction

    assign base   = addr_q & ~AW'(NB - 1);
    assign merged = (state == WAIT1) ? {bus_rsp_data, beat0_q} : {{DW{1'b0}}, bus_rsp_data};
    assign result = extract(merged, addr_q[LB-1:0], op_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!op_legal(req_op) ||
                        (ALLOW_UNALIGNED == 0 && misaligned(req_op, req_addr[LB-1:0])))
                        state_nx = RESP;
                    else
                        state_nx = BUS0;
                end
            end
            BUS0:  if (bus_req_ready) state_nx = WAIT0;
            WAIT0: if (bus_rsp_valid) state_nx = crosses(op_q, addr_q[LB-1:0]) ? BUS1 : RESP;
            BUS1:  if (bus_req_ready) state_nx = WAIT1;
            WAIT1: if (bus_rsp_valid) state_nx = RESP;
            RESP:  if (rsp_ready)     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        op_q   <= req_op;
                        err_q  <= (state_nx == RESP);
                        if (state_nx == RESP)
                            rdata_q <= ERR_DATA;
                    end
                end
                WAIT0: begin
                    if (bus_rsp_valid) begin
                        beat0_q <= bus_rsp_data;
                        if (state_nx == RESP)
                            rdata_q <= result;
                    end
                end
                WAIT1: if (bus_rsp_valid) rdata_q <= result;
                default: ;
            endcase
        end
    end

    // Bus address is only driven while a read is being offered.
    assign req_ready     = (state == IDLE);
    assign bus_req_valid = (state == BUS0) || (state == BUS1);
    assign bus_addr      = (state == BUS0) ? base :
                           (state == BUS1) ? base + AW'(NB) : '0;
    assign rsp_valid     = (state == RESP);
    assign rsp_data      = rdata_q;
    assign rsp_err       = err_q;

endmodule
